// File: rtl/tl_rx_vc_pkg.sv
// Shared definitions for the RX virtual-channel buffer write side and its buffer control.
// The write-status encoding is visible on o_w_status and decoded by buffer control.
package tl_rx_vc_pkg;

    typedef enum logic [1:0] {
        ERROR_EVALUATE = 2'b00,
        HDR_RCV        = 2'b01,
        DATA_RCV       = 2'b10,
        ERROR_CHK      = 2'b11
    } w_status_e;

endpackage

// File: rtl/tl_rx_vc_wr_ptr.sv
// Speculative write pointer paired with a committed copy; the speculative side
// advances per written entry and is either committed or rolled back per TLP.
module tl_rx_vc_wr_ptr #(
    parameter int PTR_W = 11
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             inc,
    input  logic             commit,
    input  logic             rollback,
    output logic [PTR_W-1:0] ptr,
    output logic [PTR_W-1:0] commit_ptr
);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            ptr        <= '0;
            commit_ptr <= '0;
        end else begin
            // Rollback takes priority so a dropped TLP never leaves a stray increment behind.
            if (rollback) begin
                ptr <= commit_ptr;
            end else if (inc) begin
                ptr <= ptr + 1'b1;
            end
            if (commit) begin
                commit_ptr <= ptr;
            end
        end
    end

endmodule

// File: rtl/tl_rx_vc_write_ctrl.sv
// Write-side controller for one RX VC buffer: registers TLP beats, tracks write status,
// and owns the header pointer and the speculative/committed data pointer pair.
module tl_rx_vc_write_ctrl
    import tl_rx_vc_pkg::*;
#(
    parameter int HDR_FIELD_SIZE  = 8,
    parameter int DATA_FIELD_SIZE = 12,
    parameter int BEAT_WIDTH      = 256
) (
    input  logic                       i_clk,
    input  logic                       i_n_rst,
    input  logic                       i_tlp_valid,
    input  logic                       i_tlp_sop,
    input  logic                       i_tlp_eop,
    input  logic                       i_tlp_has_data,
    input  logic [BEAT_WIDTH-1:0]      i_tlp_beat,
    output logic                       o_tlp_ready,
    input  logic                       i_err_valid,
    input  logic                       i_err_found,
    input  logic                       i_hdr_full_flag,
    input  logic                       i_data_full_flag,
    input  logic                       i_w_hdr_inc,
    input  logic                       i_w_data_ptr_ld,
    input  logic                       i_w_data_cntr_ld,
    input  logic                       i_w_data_en,
    output logic [1:0]                 o_w_status,
    output logic                       o_w_valid,
    output logic                       o_w_data_transaction,
    output logic [BEAT_WIDTH-1:0]      o_w_beat,
    output logic [HDR_FIELD_SIZE-1:0]  o_w_hdr_ptr,
    output logic [DATA_FIELD_SIZE-2:0] o_w_data_ptr,
    output logic [DATA_FIELD_SIZE-2:0] o_w_data_commit_ptr
);

    w_status_e             state, state_nxt;
    logic                  has_data, has_data_nxt;
    logic                  last_p1, last_nxt;
    logic                  vld_p1, vld_nxt;
    logic                  commit_p1, commit_nxt;
    logic                  beat_ld;
    logic                  accept;
    logic [BEAT_WIDTH-1:0] beat_p1;
    logic [HDR_FIELD_SIZE-1:0] hdr_ptr;

    assign accept = i_tlp_valid & o_tlp_ready;

    // Once the eop beat is registered no further beat may be taken until the verdict has cleared.
    always_comb begin
        o_tlp_ready = 1'b0;
        case (state)
            ERROR_EVALUATE:    o_tlp_ready = ~commit_p1 & ~i_hdr_full_flag;
            HDR_RCV, DATA_RCV: o_tlp_ready = ~last_p1 & ~(has_data & i_data_full_flag);
            default:           o_tlp_ready = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt    = state;
        has_data_nxt = has_data;
        last_nxt     = last_p1;
        vld_nxt      = 1'b0;
        commit_nxt   = 1'b0;
        beat_ld      = 1'b0;
        case (state)
            ERROR_EVALUATE: begin
                if (accept && i_tlp_sop) begin
                    state_nxt    = HDR_RCV;
                    has_data_nxt = i_tlp_has_data;
                    last_nxt     = i_tlp_eop;
                    vld_nxt      = i_tlp_has_data;
                    beat_ld      = 1'b1;
                end
            end
            HDR_RCV, DATA_RCV: begin
                if (last_p1) begin
                    state_nxt = ERROR_CHK;
                end else begin
                    state_nxt = DATA_RCV;
                    if (accept) begin
                        last_nxt = i_tlp_eop;
                        vld_nxt  = has_data;
                        beat_ld  = 1'b1;
                    end
                end
            end
            ERROR_CHK: begin
                if (i_err_valid) begin
                    state_nxt  = ERROR_EVALUATE;
                    commit_nxt = ~i_err_found;
                end
            end
            default: state_nxt = ERROR_EVALUATE;
        endcase
    end

    // Stage p1: registered beat and the status describing it.
    always_ff @(posedge i_clk) begin
        if (!i_n_rst) begin
            state     <= ERROR_EVALUATE;
            has_data  <= 1'b0;
            last_p1   <= 1'b0;
            vld_p1    <= 1'b0;
            commit_p1 <= 1'b0;
            beat_p1   <= '0;
            hdr_ptr   <= '0;
        end else begin
            state     <= state_nxt;
            has_data  <= has_data_nxt;
            last_p1   <= last_nxt;
            vld_p1    <= vld_nxt;
            commit_p1 <= commit_nxt;
            if (beat_ld) begin
                beat_p1 <= i_tlp_beat;
            end
            if (i_w_hdr_inc) begin
                hdr_ptr <= hdr_ptr + 1'b1;
            end
        end
    end

    tl_rx_vc_wr_ptr #(
        .PTR_W (DATA_FIELD_SIZE - 1)
    ) u_data_ptr (
        .clk        (i_clk),
        .n_rst      (i_n_rst),
        .inc        (i_w_data_en),
        .commit     (i_w_data_ptr_ld),
        .rollback   (i_w_data_cntr_ld),
        .ptr        (o_w_data_ptr),
        .commit_ptr (o_w_data_commit_ptr)
    );

    assign o_w_status           = state;
    assign o_w_valid            = commit_p1;
    assign o_w_data_transaction = vld_p1;
    assign o_w_beat             = beat_p1;
    assign o_w_hdr_ptr          = hdr_ptr;

endmodule

// File: tb/tb_tl_rx_vc_write_ctrl.sv
// Randomized bench for tl_rx_vc_write_ctrl: TLP-level reference model feeding a scoreboard,
// with buffer control emulated as a simple peer that follows the commit/write strobes.
module tb_tl_rx_vc_write_ctrl;
    import tl_rx_vc_pkg::*;

    localparam int HW  = 8;
    localparam int DFS = 12;
    localparam int DW  = DFS - 1;
    localparam int BW  = 256;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          tlp_valid, tlp_sop, tlp_eop, tlp_has_data;
    logic [BW-1:0] tlp_beat;
    logic          tlp_ready;
    logic          err_valid, err_found;
    logic          hdr_full, data_full;
    logic          w_hdr_inc, w_data_ptr_ld, w_data_cntr_ld, w_data_en;
    logic [1:0]    w_status;
    logic          w_valid, w_data_transaction;
    logic [BW-1:0] w_beat;
    logic [HW-1:0] w_hdr_ptr;
    logic [DW-1:0] w_data_ptr, w_data_commit_ptr;

    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;
    logic rand_full = 1'b0;

    typedef struct packed {
        logic [1:0]    st;
        logic          tr;
        logic [BW-1:0] beat;
    } beat_exp_t;

    typedef struct packed {
        logic          clean;
        logic [HW-1:0] hdr_before;
        logic [DW-1:0] commit_before;
        logic [DW-1:0] spec;
    } tlp_exp_t;

    beat_exp_t beat_q[$];
    tlp_exp_t  tlp_q[$];

    // Reference model: header ptr counts clean TLPs, committed data ptr sums their data beats.
    logic [HW-1:0] model_hdr = '0;
    logic [DW-1:0] model_commit = '0;

    always #5 clk = ~clk;

    tl_rx_vc_write_ctrl #(
        .HDR_FIELD_SIZE  (HW),
        .DATA_FIELD_SIZE (DFS),
        .BEAT_WIDTH      (BW)
    ) dut (
        .i_clk                (clk),
        .i_n_rst              (n_rst),
        .i_tlp_valid          (tlp_valid),
        .i_tlp_sop            (tlp_sop),
        .i_tlp_eop            (tlp_eop),
        .i_tlp_has_data       (tlp_has_data),
        .i_tlp_beat           (tlp_beat),
        .o_tlp_ready          (tlp_ready),
        .i_err_valid          (err_valid),
        .i_err_found          (err_found),
        .i_hdr_full_flag      (hdr_full),
        .i_data_full_flag     (data_full),
        .i_w_hdr_inc          (w_hdr_inc),
        .i_w_data_ptr_ld      (w_data_ptr_ld),
        .i_w_data_cntr_ld     (w_data_cntr_ld),
        .i_w_data_en          (w_data_en),
        .o_w_status           (w_status),
        .o_w_valid            (w_valid),
        .o_w_data_transaction (w_data_transaction),
        .o_w_beat             (w_beat),
        .o_w_hdr_ptr          (w_hdr_ptr),
        .o_w_data_ptr         (w_data_ptr),
        .o_w_data_commit_ptr  (w_data_commit_ptr)
    );

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (rand_full) begin
            hdr_full  = ($urandom_range(0, 3) == 0);
            data_full = ($urandom_range(0, 3) == 0);
        end
    endtask

    function automatic logic [BW-1:0] rand_beat();
        logic [BW-1:0] b;
        for (int k = 0; k < BW / 32; k++) b[k*32 +: 32] = $urandom();
        return b;
    endfunction

    // Buffer-control peer: writes a data entry per data beat, commits on the clean strobe.
    initial begin
        w_hdr_inc = 1'b0;
        w_data_ptr_ld = 1'b0;
        w_data_en = 1'b0;
        forever begin
            @(negedge clk);
            w_hdr_inc     = w_valid;
            w_data_ptr_ld = w_valid;
            w_data_en     = w_data_transaction;
        end
    end

    // Monitor / scoreboard.
    initial begin
        logic [1:0] prev_st;
        logic       post;
        tlp_exp_t   cur;
        beat_exp_t  eb;
        prev_st = 2'b00;
        post = 1'b0;
        cur = '0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                prev_st = w_status;
                post = 1'b0;
                continue;
            end
            if (post) begin
                post = 1'b0;
                check("hdr_ptr_after_verdict", BW'(w_hdr_ptr),
                      BW'(cur.clean ? HW'(cur.hdr_before + 1'b1) : cur.hdr_before));
                check("data_ptr_after_verdict", BW'(w_data_ptr),
                      BW'(cur.clean ? cur.spec : cur.commit_before));
                check("commit_ptr_after_verdict", BW'(w_data_commit_ptr),
                      BW'(cur.clean ? cur.spec : cur.commit_before));
                check("w_valid_single_cycle", BW'(w_valid), BW'(1'b0));
            end
            if (w_status == 2'b01 || (w_status == 2'b10 && w_data_transaction)) begin
                if (beat_q.size() == 0) begin
                    check("unexpected_beat", BW'(w_status), BW'(2'b00));
                end else begin
                    eb = beat_q.pop_front();
                    check("beat_status", BW'(w_status), BW'(eb.st));
                    check("beat_transaction", BW'(w_data_transaction), BW'(eb.tr));
                    check("beat_data", w_beat, eb.beat);
                end
            end
            if (w_status == 2'b11 && prev_st != 2'b11) begin
                check("beats_done_at_chk", BW'(beat_q.size()), BW'(0));
                if (tlp_q.size() == 0) check("unexpected_chk", BW'(w_status), BW'(2'b00));
                else check("spec_data_ptr_at_chk", BW'(w_data_ptr), BW'(tlp_q[0].spec));
            end
            if (prev_st == 2'b11 && w_status == 2'b00) begin
                if (tlp_q.size() == 0) begin
                    check("unexpected_verdict", BW'(w_valid), BW'(1'b0));
                end else begin
                    cur = tlp_q.pop_front();
                    check("w_valid_on_verdict", BW'(w_valid), BW'(cur.clean));
                    post = 1'b1;
                end
            end
            prev_st = w_status;
        end
    end

    task automatic send_beat(input logic sop, input logic eop, input logic hd, input logic [BW-1:0] b);
        int n;
        tlp_valid = 1'b0;
        while ($urandom_range(0, 3) == 0) tick();
        tlp_valid = 1'b1;
        tlp_sop = sop;
        tlp_eop = eop;
        tlp_has_data = hd;
        tlp_beat = b;
        n = 0;
        #1;
        while (!tlp_ready) begin
            tick();
            #1;
            n++;
            if (n > 300) begin
                check("beat_accept_timeout", BW'(tlp_ready), BW'(1'b1));
                tlp_valid = 1'b0;
                return;
            end
        end
        tick();
        tlp_valid = 1'b0;
        tlp_sop = 1'b0;
        tlp_eop = 1'b0;
    endtask

    task automatic run_tlp(input int nb, input logic hd, input logic bad);
        tlp_exp_t      rec;
        logic [BW-1:0] b;
        int            n;
        rec.clean = ~bad;
        rec.hdr_before = model_hdr;
        rec.commit_before = model_commit;
        rec.spec = hd ? DW'(model_commit + DW'(nb)) : model_commit;
        tlp_q.push_back(rec);
        if (!bad) begin
            model_hdr = model_hdr + 1'b1;
            model_commit = rec.spec;
        end
        for (int i = 0; i < nb; i++) begin
            b = rand_beat();
            beat_q.push_back({(i == 0) ? 2'b01 : 2'b10, hd, b});
            // has_data only matters on the sop beat; randomize it elsewhere.
            send_beat(i == 0, i == nb - 1, (i == 0) ? hd : 1'($urandom_range(0, 1)), b);
        end
        n = 0;
        while (w_status != 2'b11) begin
            tick();
            n++;
            if (n > 20) begin
                check("chk_timeout", BW'(w_status), BW'(2'b11));
                break;
            end
        end
        repeat ($urandom_range(0, 3)) tick();
        err_valid = 1'b1;
        err_found = bad;
        tick();
        err_valid = 1'b0;
        err_found = 1'b0;
        w_data_cntr_ld = bad;
        tick();
        w_data_cntr_ld = 1'b0;
    endtask

    initial begin
        n_rst = 1'b0;
        tlp_valid = 1'b0; tlp_sop = 1'b0; tlp_eop = 1'b0; tlp_has_data = 1'b0;
        tlp_beat = '0;
        err_valid = 1'b0; err_found = 1'b0;
        hdr_full = 1'b0; data_full = 1'b0;
        w_data_cntr_ld = 1'b0;
        repeat (3) tick();
        n_rst = 1'b1;
        #1;
        check("rst_status", BW'(w_status), BW'(2'b00));
        check("rst_w_valid", BW'(w_valid), BW'(1'b0));
        check("rst_transaction", BW'(w_data_transaction), BW'(1'b0));
        check("rst_beat", w_beat, '0);
        check("rst_hdr_ptr", BW'(w_hdr_ptr), BW'(0));
        check("rst_data_ptr", BW'(w_data_ptr), BW'(0));
        check("rst_commit_ptr", BW'(w_data_commit_ptr), BW'(0));
        check("rst_ready", BW'(tlp_ready), BW'(1'b1));
        mon_en = 1'b1;

        // Header buffer full: sop is held off until the flag drops.
        hdr_full = 1'b1;
        tlp_valid = 1'b1; tlp_sop = 1'b1; tlp_eop = 1'b1; tlp_beat = rand_beat();
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            check("ready_hdr_full", BW'(tlp_ready), BW'(1'b0));
            check("status_hdr_full", BW'(w_status), BW'(2'b00));
        end
        hdr_full = 1'b0;
        #1;
        check("ready_hdr_free", BW'(tlp_ready), BW'(1'b1));
        tlp_valid = 1'b0;
        tick();

        run_tlp(1, 1'b0, 1'b0);
        run_tlp(3, 1'b1, 1'b0);
        run_tlp(3, 1'b1, 1'b1);

        rand_full = 1'b1;
        for (int t = 0; t < 700; t++) begin
            logic hd;
            hd = ($urandom_range(0, 3) != 0);
            run_tlp(hd ? int'($urandom_range(1, 12)) : 1, hd, $urandom_range(0, 3) == 0);
        end
        rand_full = 1'b0;
        hdr_full = 1'b0;
        data_full = 1'b0;
        repeat (4) tick();
        check("beat_q_drained", BW'(beat_q.size()), BW'(0));
        check("tlp_q_drained", BW'(tlp_q.size()), BW'(0));
        check("final_hdr_ptr", BW'(w_hdr_ptr), BW'(model_hdr));
        check("final_commit_ptr", BW'(w_data_commit_ptr), BW'(model_commit));

        // Reset in the middle of a data TLP discards it and clears the pointers.
        mon_en = 1'b0;
        send_beat(1'b1, 1'b0, 1'b1, rand_beat());
        send_beat(1'b0, 1'b0, 1'b1, rand_beat());
        tick();
        n_rst = 1'b0;
        tick();
        n_rst = 1'b1;
        #1;
        check("midrst_status", BW'(w_status), BW'(2'b00));
        check("midrst_hdr_ptr", BW'(w_hdr_ptr), BW'(0));
        check("midrst_data_ptr", BW'(w_data_ptr), BW'(0));
        check("midrst_commit_ptr", BW'(w_data_commit_ptr), BW'(0));
        check("midrst_transaction", BW'(w_data_transaction), BW'(1'b0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
